fpu_sqrt_seq: RTL

Iterative IEEE-754 single-precision square-root unit. It fills the `FPU_SQRT` (fpu_control = 2'b11) leg of the FPU result mux, which has no combinational implementation. It takes rs1 with a start pulse, computes one root bit per cycle with a restoring digit recurrence, rounds to nearest-even, and returns the result with a one-cycle done pulse. The core stalls on `busy`.

---
 rtl/fpu_pkg.sv | 35 +++
 rtl/fpu_sqrt_seq_if.sv | 14 +
 rtl/sqrt_iter_step.sv | 21 ++
 rtl/fpu_sqrt_seq.sv | 120 ++++++++++++
 4 files changed

// File: rtl/fpu_pkg.sv
// rtl/fpu_pkg.sv - FP32 field layout, FPU opcodes and sqrt unit constants
package fpu_pkg;

  localparam int FP_WIDTH    = 32;
  localparam int FP_SIGN_BIT = 31;
  localparam int FP_EXP_MSB  = 30;
  localparam int FP_EXP_LSB  = 23;
  localparam int FP_FRAC_MSB = 22;
  localparam int FP_FRAC_LSB = 0;
  localparam int FP_EXP_W    = 8;
  localparam int FP_FRAC_W   = 23;

  localparam logic [FP_WIDTH-1:0] CANON_NAN  = 32'h7FC0_0000;
  localparam logic [FP_WIDTH-1:0] FP_POS_INF = 32'h7F80_0000;

  // Restoring recurrence sizing: 2 radicand bits per step, 25 root bits
  localparam int SQRT_REM_W  = 27;
  localparam int SQRT_ROOT_W = 25;
  localparam int SQRT_RAD_W  = 50;
  localparam int SQRT_ITERS  = 25;

  typedef enum logic [1:0] {
    IDLE,
    ITER,
    ROUND
  } sqrt_state_e;

  typedef enum logic [1:0] {
    FPU_ADD  = 2'b00,
    FPU_SUB  = 2'b01,
    FPU_MUL  = 2'b10,
    FPU_SQRT = 2'b11
  } fpu_op_e;

endpackage

// File: rtl/fpu_sqrt_seq_if.sv
// rtl/fpu_sqrt_seq_if.sv - request/response bundle between core and sqrt unit
interface fpu_sqrt_seq_if;
  import fpu_pkg::*;

  logic                start;
  logic [FP_WIDTH-1:0] a;
  logic                busy;
  logic                done;
  logic [FP_WIDTH-1:0] result;

  modport master (output start, a, input busy, done, result);
  modport slave  (input start, a, output busy, done, result);

endinterface

// File: rtl/sqrt_iter_step.sv
// rtl/sqrt_iter_step.sv - one restoring square-root digit step (combinational)
module sqrt_iter_step
  import fpu_pkg::*;
(
  input  logic [SQRT_REM_W-1:0]  rem,
  input  logic [SQRT_ROOT_W-1:0] root,
  input  logic [1:0]             rad_bits,
  output logic [SQRT_REM_W-1:0]  rem_next,
  output logic                   root_bit
);

  // One spare MSB so the trial subtraction sign is never lost
  logic [SQRT_REM_W+2:0] shifted;
  logic [SQRT_REM_W+2:0] trial;

  assign shifted  = {1'b0, rem, rad_bits};
  assign trial    = shifted - {3'b000, root, 2'b01};
  assign root_bit = ~trial[SQRT_REM_W+2];
  assign rem_next = SQRT_REM_W'(root_bit ? trial : shifted);

endmodule

// File: rtl/fpu_sqrt_seq.sv
// rtl/fpu_sqrt_seq.sv - iterative FP32 square root, one root bit per cycle, RNE
module fpu_sqrt_seq #(
  parameter logic [31:0] CANON_NAN = fpu_pkg::CANON_NAN
) (
  input logic                clk,
  input logic                rst_n,
  fpu_sqrt_seq_if.slave      bus
);
  import fpu_pkg::*;

  localparam logic [4:0] LAST_ITER = 5'(SQRT_ITERS - 1);

  sqrt_state_e             state, state_next;
  logic [4:0]              iter_cnt;
  logic [SQRT_RAD_W-1:0]   rad;
  logic [SQRT_REM_W-1:0]   rem;
  logic [SQRT_REM_W-1:0]   rem_next;
  logic [SQRT_ROOT_W-1:0]  root;
  logic                    root_bit;
  logic [FP_EXP_W-1:0]     res_exp;
  logic                    special;
  logic [FP_WIDTH-1:0]     special_val;
  logic                    done_q;
  logic [FP_WIDTH-1:0]     result_q;

  logic                    a_sign;
  logic [FP_EXP_W-1:0]     a_exp;
  logic [FP_FRAC_W-1:0]    a_frac;
  logic                    is_nan, is_zero, is_special;
  logic [FP_WIDTH-1:0]     spec_val;
  logic [FP_EXP_W:0]       exp_sum;

  assign a_sign = bus.a[FP_SIGN_BIT];
  assign a_exp  = bus.a[FP_EXP_MSB:FP_EXP_LSB];
  assign a_frac = bus.a[FP_FRAC_MSB:FP_FRAC_LSB];

  // Negative denormals count as non-zero magnitude, so they decode to NaN
  assign is_nan     = (a_exp == 8'hFF && a_frac != '0) || (a_sign && bus.a[FP_EXP_MSB:0] != '0);
  assign is_zero    = (a_exp == '0);
  assign is_special = is_nan || is_zero || (a_exp == 8'hFF);
  assign spec_val   = is_nan  ? CANON_NAN :
                      is_zero ? {a_sign, 31'b0} : FP_POS_INF;
  assign exp_sum    = {1'b0, a_exp} + 9'd127;

  sqrt_iter_step u_step (
    .rem      (rem),
    .root     (root),
    .rad_bits (rad[SQRT_RAD_W-1 -: 2]),
    .rem_next (rem_next),
    .root_bit (root_bit)
  );

  logic                 sticky, round_inc, carry;
  logic [FP_FRAC_W-1:0] mant_r;
  logic [FP_WIDTH-1:0]  rounded;

  assign sticky             = (rem != '0);
  assign round_inc          = root[0] && (sticky || root[1]);
  assign {carry, mant_r}    = {1'b0, root[FP_FRAC_W:1]} + 24'(round_inc);
  assign rounded            = {1'b0, res_exp + 8'(carry), mant_r};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.start) state_next = is_special ? ROUND : ITER;
      ITER:    if (iter_cnt == LAST_ITER) state_next = ROUND;
      ROUND:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      iter_cnt    <= '0;
      rad         <= '0;
      rem         <= '0;
      root        <= '0;
      res_exp     <= '0;
      special     <= 1'b0;
      special_val <= '0;
      done_q      <= 1'b0;
      result_q    <= '0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: if (bus.start) begin
          special     <= is_special;
          special_val <= spec_val;
          res_exp     <= 8'(exp_sum >> 1);
          // Even biased exponent means odd unbiased: pre-double the significand
          rad         <= a_exp[0] ? {2'b01, a_frac, 25'b0} : {1'b1, a_frac, 26'b0};
          rem         <= '0;
          root        <= '0;
          iter_cnt    <= '0;
        end
        ITER: begin
          rem      <= rem_next;
          root     <= {root[SQRT_ROOT_W-2:0], root_bit};
          rad      <= rad << 2;
          iter_cnt <= iter_cnt + 5'd1;
        end
        ROUND: begin
          result_q <= special ? special_val : rounded;
          done_q   <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy   = (state != IDLE);
  assign bus.done   = done_q;
  assign bus.result = result_q;

endmodule
